// File: rtl/disp_pkg.sv
// disp_pkg: shared FSM encoding, service codes and BCD segment table for the display owner.
package disp_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_SVC1, ST_SVC2, ST_SVC3, ST_SVC4, ST_DONE} state_t;
    localparam logic [3:0] SVC1_CODE = 4'b1000;
    localparam logic [3:0] SVC2_CODE = 4'b0100;
    localparam logic [3:0] SVC3_CODE = 4'b0010;
    localparam logic [3:0] SVC4_CODE = 4'b0001;
    localparam logic [3:0] ANODE_OFF = 4'b1111;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    function automatic logic [3:0] svc_code(state_t s);
        return s == ST_SVC1 ? SVC1_CODE : s == ST_SVC2 ? SVC2_CODE :
               s == ST_SVC3 ? SVC3_CODE : s == ST_SVC4 ? SVC4_CODE : 4'b0000;
    endfunction
    function automatic state_t code_state(logic [3:0] c);
        return c == SVC1_CODE ? ST_SVC1 : c == SVC2_CODE ? ST_SVC2 :
               c == SVC3_CODE ? ST_SVC3 : c == SVC4_CODE ? ST_SVC4 : ST_IDLE;
    endfunction
    function automatic logic [6:0] bcd_seg(logic [3:0] d);
        case (d)
            4'd0: return 7'b0111111;
            4'd1: return 7'b0000110;
            4'd2: return 7'b1011011;
            4'd3: return 7'b1001111;
            4'd4: return 7'b1100110;
            4'd5: return 7'b1101101;
            4'd6: return 7'b1111101;
            4'd7: return 7'b0000111;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction
endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: combinational BCD to {g..a} segments, non-BCD codes dark.
module seg7_decoder
    import disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);
    assign o_seg = bcd_seg(i_bcd);
endmodule

// File: rtl/display_owner_ctrl.sv
// display_owner_ctrl: service-mode FSM owning a scanned 4-digit 7-segment display with edit blink.
module display_owner_ctrl
    import disp_pkg::*;
#(
    parameter int SCAN_DIV  = 65536,
    parameter int BLINK_DIV = 25000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  spdt_svc,
    input  logic [3:0]  finish,
    input  logic [15:0] num_time,
    input  logic [15:0] num_alarm,
    input  logic [15:0] num_sw,
    input  logic [15:0] num_clock,
    input  logic [3:0]  sel,
    output logic [3:0]  svc_led,
    output logic [3:0]  anode,
    output logic [7:0]  eseg
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    state_t          r_state, w_next;
    logic [3:0]      r_svc_led, r_anode, w_code, w_digit;
    logic [7:0]      r_eseg;
    logic [SW-1:0]   r_scan_cnt;
    logic [BW-1:0]   r_blink_cnt;
    logic [1:0]      r_idx;
    logic            r_phase, w_scan_wrap, w_blink_wrap, w_sel_ok, w_blank;
    logic [15:0]     w_num;
    logic [6:0]      w_seg;
    assign w_code       = svc_code(r_state);
    assign w_scan_wrap  = r_scan_cnt == SW'(SCAN_DIV - 1);
    assign w_blink_wrap = r_blink_cnt == BW'(BLINK_DIV - 1);
    assign w_num        = r_state == ST_SVC1 ? num_time : r_state == ST_SVC2 ? num_alarm :
                          r_state == ST_SVC3 ? num_sw : num_clock;
    assign w_digit      = w_num[{r_idx, 2'b00} +: 4];
    assign w_sel_ok     = sel != 4'b0000 && (sel & (sel - 4'd1)) == 4'b0000;
    assign w_blank      = (r_state == ST_SVC1 || r_state == ST_SVC2) && w_sel_ok && sel[r_idx] && !r_phase;
    seg7_decoder u_dec (.i_bcd(w_digit), .o_seg(w_seg));
    // An owner's own finish takes priority over its switch dropping in the same cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = code_state(spdt_svc);
            ST_DONE: w_next = spdt_svc == 4'b0000 ? ST_IDLE : ST_DONE;
            default: w_next = |(finish & w_code) ? ST_DONE : spdt_svc != w_code ? ST_IDLE : r_state;
        endcase
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_svc_led   <= 4'b0000;
            r_anode     <= ANODE_OFF;
            r_eseg      <= SEG_BLANK;
            r_scan_cnt  <= '0;
            r_blink_cnt <= '0;
            r_idx       <= 2'd0;
            r_phase     <= 1'b1;
        end else begin
            r_state     <= w_next;
            r_svc_led   <= svc_code(w_next);
            r_scan_cnt  <= w_scan_wrap ? '0 : r_scan_cnt + 1'b1;
            r_idx       <= r_idx + {1'b0, w_scan_wrap};
            r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + 1'b1;
            r_phase     <= r_phase ^ w_blink_wrap;
            // Slot start: anode and segments latch together from the same digit sample.
            if (r_scan_cnt == '0) begin
                r_anode <= w_blank ? ANODE_OFF : ~(4'b0001 << r_idx);
                r_eseg  <= w_blank ? SEG_BLANK : {r_idx == 2'd2, w_seg};
            end
        end
    end
    assign svc_led = r_svc_led;
    assign anode   = r_anode;
    assign eseg    = r_eseg;
endmodule

// File: tb/tb_display_owner_ctrl.sv
// tb_display_owner_ctrl: directed scenarios plus randomized traffic against a cycle-count based model.
module tb_display_owner_ctrl;
    localparam int SD = 4;
    localparam int BD = 8;
    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [3:0]  spdt_svc = 4'h0, finish = 4'h0, sel = 4'h0;
    logic [15:0] num_time = 16'h0, num_alarm = 16'h0, num_sw = 16'h0, num_clock = 16'h1234;
    logic [3:0]  svc_led, anode;
    logic [7:0]  eseg;
    int          checks = 0, fails = 0;
    int          k, own;
    logic [3:0]  e_led, e_anode, e_c;
    logic [7:0]  e_eseg;
    logic        cmp_en = 1'b0, got;
    logic [6:0]  segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    always #5 clk = ~clk;
    display_owner_ctrl #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk(clk), .resetn(resetn), .spdt_svc(spdt_svc), .finish(finish),
        .num_time(num_time), .num_alarm(num_alarm), .num_sw(num_sw), .num_clock(num_clock),
        .sel(sel), .svc_led(svc_led), .anode(anode), .eseg(eseg)
    );
    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask
    // Model: k counts clock edges since reset release; slot, digit and blink phase follow from it.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            k = 0; own = 0; e_led = 4'h0; e_anode = 4'hF; e_eseg = 8'h00;
        end else begin
            if (k % SD == 0) begin
                int idx;
                logic [15:0] num;
                logic [3:0] d;
                logic blank;
                idx   = (k / SD) % 4;
                num   = own == 1 ? num_time : own == 2 ? num_alarm : own == 3 ? num_sw : num_clock;
                d     = num[4*idx +: 4];
                blank = (own == 1 || own == 2) && $countones(sel) == 1 && sel[idx] && ((k / BD) % 2 == 1);
                e_anode = blank ? 4'hF : 4'hF ^ 4'(1 << idx);
                e_eseg  = blank ? 8'h00 : {idx == 2, segtab[d]};
            end
            if (own == 0)
                own = spdt_svc == 4'b1000 ? 1 : spdt_svc == 4'b0100 ? 2 :
                      spdt_svc == 4'b0010 ? 3 : spdt_svc == 4'b0001 ? 4 : 0;
            else if (own == 5)
                own = spdt_svc == 4'b0000 ? 0 : 5;
            else begin
                e_c = 4'(8 >> (own - 1));
                own = (finish & e_c) != 4'h0 ? 5 : spdt_svc != e_c ? 0 : own;
            end
            e_led = (own >= 1 && own <= 4) ? 4'(8 >> (own - 1)) : 4'h0;
            k++;
        end
    end
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_svc_led", {12'h0, svc_led}, {12'h0, e_led});
            chk("model_anode", {12'h0, anode}, {12'h0, e_anode});
            chk("model_eseg", {8'h0, eseg}, {8'h0, e_eseg});
        end
    end
    initial begin
        #1 resetn = 1'b0;
        cmp_en = 1'b1;
        #1;
        chk("reset_anode", {12'h0, anode}, 16'h000F);
        chk("reset_eseg", {8'h0, eseg}, 16'h0000);
        chk("reset_led", {12'h0, svc_led}, 16'h0000);
        tick(2);
        resetn = 1'b1;
        tick(1);
        chk("first_idx0_anode", {12'h0, anode}, 16'h000E);
        chk("first_idx0_seg4", {8'h0, eseg}, 16'h0066);
        tick(8);
        chk("idx2_anode", {12'h0, anode}, 16'h000B);
        chk("idx2_seg2_dp", {8'h0, eseg}, 16'h00DB);
        spdt_svc = 4'b1000; num_time = 16'h0930; sel = 4'b0010;
        tick(1);
        chk("svc1_led", {12'h0, svc_led}, 16'h0008);
        tick(40);
        spdt_svc = 4'b0100;
        tick(3);
        chk("svc2_led", {12'h0, svc_led}, 16'h0004);
        finish = 4'b0100;
        tick(1);
        finish = 4'b0000;
        chk("done_led", {12'h0, svc_led}, 16'h0000);
        tick(5);
        chk("done_hold_led", {12'h0, svc_led}, 16'h0000);
        spdt_svc = 4'b0000;
        tick(1);
        spdt_svc = 4'b0010;
        tick(1);
        chk("svc3_led", {12'h0, svc_led}, 16'h0002);
        finish = 4'b1000;
        tick(1);
        finish = 4'b0000;
        chk("foreign_finish_ignored", {12'h0, svc_led}, 16'h0002);
        finish = 4'b0010; spdt_svc = 4'b0000;
        tick(1);
        finish = 4'b0000; spdt_svc = 4'b0010;
        tick(1);
        chk("finish_wins_done", {12'h0, svc_led}, 16'h0000);
        spdt_svc = 4'b0000;
        tick(1);
        spdt_svc = 4'b1100;
        tick(3);
        chk("multihot_idle", {12'h0, svc_led}, 16'h0000);
        spdt_svc = 4'b0010; num_sw = 16'h00AF;
        tick(17);
        got = 1'b0;
        for (int i = 0; i < 24 && !got; i++) begin
            @(negedge clk);
            got = anode == 4'b1110;
        end
        chk("wait_sw_idx0", {15'h0, got}, 16'h0001);
        chk("sw_idx0_hex_dark", {8'h0, eseg}, 16'h0000);
        got = 1'b0;
        for (int i = 0; i < 24 && !got; i++) begin
            @(negedge clk);
            got = anode == 4'b1101;
        end
        chk("wait_sw_idx1", {15'h0, got}, 16'h0001);
        chk("sw_idx1_hex_dark", {8'h0, eseg}, 16'h0000);
        spdt_svc = 4'b1000;
        tick(3);
        chk("svc1_again_led", {12'h0, svc_led}, 16'h0008);
        tick(1);
        #2 resetn = 1'b0;
        #1;
        chk("midslot_reset_anode", {12'h0, anode}, 16'h000F);
        chk("midslot_reset_led", {12'h0, svc_led}, 16'h0000);
        @(negedge clk);
        resetn = 1'b1;
        tick(1);
        chk("release_idx0", {12'h0, anode}, 16'h000E);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 5))
                    0: spdt_svc = 4'b0000;
                    5: spdt_svc = 4'($urandom);
                    default: spdt_svc = 4'(1 << $urandom_range(0, 3));
                endcase
            end
            finish = $urandom_range(0, 5) == 0 ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 15) == 0)
                sel = $urandom_range(0, 1) == 1 ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                num_time = 16'($urandom); num_alarm = 16'($urandom);
                num_sw = 16'($urandom); num_clock = 16'($urandom);
            end
            if ($urandom_range(0, 499) == 0) begin
                #2 resetn = 1'b0;
                @(negedge clk);
                resetn = 1'b1;
            end
        end
        tick(2);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
